// File: rtl/ysyx_22050243_regfile_sb.sv
// ysyx_22050243_regfile_sb: 32 x XLEN integer register file with issue scoreboard.
// Optional macro NPC_RF_BYPASS_EN enables writeback-to-read forwarding and
// lets the hazard check see a same-cycle writeback as already retired.
module ysyx_22050243_regfile_sb #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NR_REG = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    input  logic              rs1_used,
    input  logic              rs2_used,
    output logic [XLEN-1:0]   rs1_data,
    output logic [XLEN-1:0]   rs2_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_rd_wen,
    output logic              issue_ready,
    input  logic              wb_wen,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    output logic [NR_REG-1:0] busy_vec
);

    logic [XLEN-1:0]   regs_q [NR_REG];
    logic [NR_REG-1:0] busy_q;
    logic [NR_REG-1:0] busy_d;
    logic [NR_REG-1:0] wb_onehot;
    logic [NR_REG-1:0] issue_onehot;
    logic [NR_REG-1:0] busy_eff;
    logic              issue_fire;

    // One-hot write-enable decode; x0 never gets an enable bit
    always_comb begin
        wb_onehot = '0;
        for (int i = 1; i < NR_REG; i++) begin
            wb_onehot[i] = wb_wen && (wb_addr == ADDR_W'(i));
        end
    end

    // One-hot destination decode for the scoreboard set path
    always_comb begin
        issue_onehot = '0;
        for (int i = 1; i < NR_REG; i++) begin
            issue_onehot[i] = issue_fire && (issue_rd == ADDR_W'(i));
        end
    end

    // Scoreboard view used by the hazard check
`ifdef NPC_RF_BYPASS_EN
    always_comb busy_eff = busy_q & ~wb_onehot;
`else
    always_comb busy_eff = busy_q;
`endif

    // RAW on used sources, WAW on the destination; independent of issue_valid
    always_comb begin
        issue_ready = !(rs1_used && busy_eff[rs1_addr])
                   && !(rs2_used && busy_eff[rs2_addr])
                   && !(issue_rd_wen && busy_eff[issue_rd]);
    end

    assign issue_fire = issue_valid && issue_ready && issue_rd_wen && (issue_rd != '0);

    // Keyed read mux; index 0 reads as zero, optional writeback forwarding
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) rs1_data = regs_q[rs1_addr];
        if (rs2_addr != '0) rs2_data = regs_q[rs2_addr];
`ifdef NPC_RF_BYPASS_EN
        if (wb_wen && (wb_addr != '0) && (wb_addr == rs1_addr)) rs1_data = wb_data;
        if (wb_wen && (wb_addr != '0) && (wb_addr == rs2_addr)) rs2_data = wb_data;
`endif
    end

    // Next scoreboard: flush clears everything, otherwise a new producer beats a retiring one
    always_comb begin
        busy_d = '0;
        if (!flush) begin
            busy_d = (busy_q & ~wb_onehot) | issue_onehot;
        end
        busy_d[0] = 1'b0;
    end

    // Register array write, one entry per cycle through the one-hot enable
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NR_REG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NR_REG; i++) begin
                if (wb_onehot[i]) regs_q[i] <= wb_data;
            end
        end
    end

    // Scoreboard state register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: doc/ysyx_22050243_regfile_sb.md
Name: ysyx_22050243_regfile_sb

Overview:
- 32-entry integer register file with an attached scoreboard, sitting directly downstream of the decode stage.
- Decode stage drives register addresses. Internally, write address goes through a 5-to-32 one-hot write-enable decode. Read selection is a 32-way keyed mux.
- Scoreboard tracks registers with an outstanding (issued, not yet written back) producer. It raises an issue stall on RAW/WAW hazards.
- Consumed by the issue/execute stage (operands, ready) and written by the writeback stage.

Parameters:
- XLEN, 64, register data width.
- NR_REG, 32, number of architectural registers; x0 hardwired to zero.
- ADDR_W, 5, register address width; NR_REG == 2**ADDR_W.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- rs1_addr  input  ADDR_W  source register 1 index.
- rs2_addr  input  ADDR_W  source register 2 index.
- rs1_used  input  1  instruction reads rs1 (participates in hazard check).
- rs2_used  input  1  instruction reads rs2.
- rs1_data  output  XLEN  register rs1 contents.
- rs2_data  output  XLEN  register rs2 contents.
- issue_valid  input  1  decode presents an instruction for issue.
- issue_rd  input  ADDR_W  destination of issuing instruction.
- issue_rd_wen  input  1  issuing instruction writes issue_rd.
- issue_ready  output  1  no hazard; instruction issues when issue_valid && issue_ready.
- wb_wen  input  1  writeback strobe.
- wb_addr  input  ADDR_W  writeback destination.
- wb_data  input  XLEN  writeback value.
- flush  input  1  discard all outstanding producers (branch mispredict/trap).
- busy_vec  output  NR_REG  current scoreboard bits, bit i = register i pending.

Behaviour:
- Reset (rst=1 at clk edge): all registers := 0; busy_vec := 0. After reset, rs1_data/rs2_data read 0 and issue_ready = 1.
- Reads: combinational, zero latency. Index 0 always returns 0 regardless of stored state.
- Write:
  - On clk edge with wb_wen=1 and wb_addr!=0, reg[wb_addr] := wb_data.
  - wb_addr==0 is ignored entirely (no data write, no scoreboard change).
  - Exactly one entry is updated per cycle via one-hot decode.
- Scoreboard:
  - busy[0] is constant 0.
  - Set busy[issue_rd] when issue_valid && issue_ready && issue_rd_wen && issue_rd!=0.
  - Clear busy[wb_addr] when wb_wen && wb_addr!=0.
  - Set and clear of the same index in the same cycle: set wins, because a new producer supersedes the old one.
  - flush=1: all busy bits := 0 at the edge. A coincident issue set is also suppressed. The register write still occurs.
  - rst has priority over flush, writeback and issue.
- Hazard (combinational):
  - issue_ready = !(rs1_used && busy[rs1_addr]) && !(rs2_used && busy[rs2_addr]) && !(issue_rd_wen && busy[issue_rd]).
  - issue_ready is independent of issue_valid.
- Same-cycle writeback vs read, without the optional feature:
  - rs*_data shows the old value.
  - busy still reads 1, so issue_ready=0. The instruction retries next cycle and sees the new value.
- Outstanding writebacks may complete in any order; the scoreboard holds at most one pending bit per register.

Optional Feature:
- Macro NPC_RF_BYPASS_EN enables writeback-to-read forwarding.
- When defined:
  - If wb_wen && wb_addr!=0 && wb_addr==rsN_addr, rsN_data = wb_data in the same cycle.
  - The hazard check treats busy[wb_addr] as already cleared for that cycle, so a dependent instruction issues one cycle earlier.
  - If issue_rd==wb_addr, the WAW term is also cleared.
- When undefined: no forwarding; behaviour exactly as in Behaviour.

Test Plan:
- Reset, then read all 32 indices -> all 0; busy_vec=0; issue_ready=1.
- Write x5=0xDEADBEEF_00000001, then x0=0xFFFF... -> read x5 returns 0xDEADBEEF_00000001; read x0 returns 0; busy_vec unchanged.
- Issue rd=7, then next cycle issue rs1=7 with rs1_used=1 -> issue_ready=0 and busy_vec=0x80. Writeback x7=0x42 -> without bypass, ready=1 the following cycle with rs1_data=0x42. With NPC_RF_BYPASS_EN, ready=1 in the writeback cycle with rs1_data=0x42.
- Same cycle: writeback x9 and issue rd=9 -> busy[9] remains 1 afterwards; x9 holds wb_data.
- Issue rd=3,4,6, then assert flush -> busy_vec=0 next cycle; an instruction issued in the flush cycle leaves no busy bit.
- Issue rd=0, and rs2_used=0 with rs2_addr busy -> issue_ready=1; busy_vec stays 0.
